mem_arbiter: RTL

- Two-port arbiter that merges the instruction-fetch port and the data-access port into the single request port of the Avalon bridge directly downstream.
- Latches single-cycle request pulses from each requester and serialises them: one transaction is outstanding toward the bridge at a time.
- Uses round-robin selection when both ports are waiting.
- Routes the bridge's ready/rdata response back to the port that owns the transaction.

---
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Merges the instruction-fetch port (imem_*) and the data-access port (dmem_*)
// into the single request port (mem_*) of the downstream Avalon bridge.
// Each requester issues single-cycle valid pulses, which are held in a
// one-entry pending register per port. Only one transaction is outstanding
// toward the bridge at a time. When both ports are waiting, round-robin
// selection applies. The bridge's ready/rdata response is routed back to the
// port that owns the in-flight transaction.
//
// Ports:
//   clock, reset            system clock; synchronous active-low reset
//   imem_valid/instr/addr/wdata/wstrb  instruction-port request (pulse)
//   imem_rdata, imem_ready  instruction-port response (combinational)
//   dmem_valid/instr/addr/wdata/wstrb  data-port request (pulse)
//   dmem_rdata, dmem_ready  data-port response (combinational)
//   mem_valid/instr/addr/wdata/wstrb   registered request to the bridge
//   mem_rdata, mem_ready    bridge response
module mem_arbiter (
    input  logic        clock,
    input  logic        reset,

    input  logic        imem_valid,
    input  logic        imem_instr,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,

    input  logic        dmem_valid,
    input  logic        dmem_instr,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Pending request registers, one entry per port.
    logic        r_ip_valid;
    logic        r_ip_instr;
    logic [31:0] r_ip_addr;
    logic [31:0] r_ip_wdata;
    logic [3:0]  r_ip_wstrb;

    logic        r_dp_valid;
    logic        r_dp_instr;
    logic [31:0] r_dp_addr;
    logic [31:0] r_dp_wdata;
    logic [3:0]  r_dp_wstrb;

    logic        r_owner;       // 0 = imem, 1 = dmem
    logic        r_last_grant;  // 0 = imem, 1 = dmem

    logic        w_i_cand;
    logic        w_d_cand;
    logic        w_arb_open;
    logic        w_issue;
    logic        w_grant;
    logic        w_sel_instr;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_wstrb;
    logic        w_done;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, arbitration and response routing.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_grant      = 1'b0;
        w_sel_instr  = 1'b0;
        w_sel_addr   = '0;
        w_sel_wdata  = '0;
        w_sel_wstrb  = '0;
        imem_ready   = 1'b0;
        imem_rdata   = '0;
        dmem_ready   = 1'b0;
        dmem_rdata   = '0;

        // A pending entry or a same-cycle pulse (bypass) both count.
        w_i_cand = r_ip_valid | imem_valid;
        w_d_cand = r_dp_valid | dmem_valid;

        w_done = (r_state == ST_BUSY) && mem_ready;

        // The completing cycle also arbitrates, so a queued or coincident
        // request reaches the bridge on the very next cycle instead of
        // spending one cycle in IDLE first.
        w_arb_open = (r_state == ST_IDLE) || w_done;

        if (w_done) begin
            w_state_next = ST_IDLE;
        end

        if (w_arb_open && (w_i_cand || w_d_cand)) begin
            w_issue      = 1'b1;
            w_grant      = (w_i_cand && w_d_cand) ? ~r_last_grant : w_d_cand;
            w_state_next = ST_BUSY;
        end

        if (!w_grant) begin
            w_sel_instr = r_ip_valid ? r_ip_instr : imem_instr;
            w_sel_addr  = r_ip_valid ? r_ip_addr  : imem_addr;
            w_sel_wdata = r_ip_valid ? r_ip_wdata : imem_wdata;
            w_sel_wstrb = r_ip_valid ? r_ip_wstrb : imem_wstrb;
        end else begin
            w_sel_instr = r_dp_valid ? r_dp_instr : dmem_instr;
            w_sel_addr  = r_dp_valid ? r_dp_addr  : dmem_addr;
            w_sel_wdata = r_dp_valid ? r_dp_wdata : dmem_wdata;
            w_sel_wstrb = r_dp_valid ? r_dp_wstrb : dmem_wstrb;
        end

        // Responses are held off while reset is asserted.
        if (reset && w_done) begin
            if (!r_owner) begin
                imem_ready = 1'b1;
                imem_rdata = mem_rdata;
            end else begin
                dmem_ready = 1'b1;
                dmem_rdata = mem_rdata;
            end
        end
    end

    // Bridge request registers and grant bookkeeping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_valid    <= 1'b0;
            mem_instr    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
        end else begin
            mem_valid <= w_issue;
            if (w_issue) begin
                mem_instr    <= w_sel_instr;
                mem_addr     <= w_sel_addr;
                mem_wdata    <= w_sel_wdata;
                mem_wstrb    <= w_sel_wstrb;
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
            end
        end
    end

    // Instruction-port pending entry. A granted port's entry is consumed;
    // a bypassed pulse is never stored; a pulse into a full entry is dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ip_valid <= 1'b0;
            r_ip_instr <= 1'b0;
            r_ip_addr  <= '0;
            r_ip_wdata <= '0;
            r_ip_wstrb <= '0;
        end else if (w_issue && !w_grant) begin
            r_ip_valid <= 1'b0;
        end else if (imem_valid && !r_ip_valid) begin
            r_ip_valid <= 1'b1;
            r_ip_instr <= imem_instr;
            r_ip_addr  <= imem_addr;
            r_ip_wdata <= imem_wdata;
            r_ip_wstrb <= imem_wstrb;
        end
    end

    // Data-port pending entry, same rules as the instruction port.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dp_valid <= 1'b0;
            r_dp_instr <= 1'b0;
            r_dp_addr  <= '0;
            r_dp_wdata <= '0;
            r_dp_wstrb <= '0;
        end else if (w_issue && w_grant) begin
            r_dp_valid <= 1'b0;
        end else if (dmem_valid && !r_dp_valid) begin
            r_dp_valid <= 1'b1;
            r_dp_instr <= dmem_instr;
            r_dp_addr  <= dmem_addr;
            r_dp_wdata <= dmem_wdata;
            r_dp_wstrb <= dmem_wstrb;
        end
    end

endmodule
